ps2_frame_rx: RTL and testbench



---
 rtl/ps2_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// frame FSM with timeout recovery and a first-word-fall-through scancode FIFO.
module ps2_frame_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          csi_clk,
  input  logic                          csi_reset_n,
  input  logic                          coe_kc,
  input  logic                          coe_kd,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [7:0]                    data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity over the data byte plus its parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    parity_ok = ^{d, p};
  endfunction

  logic          kc_s1_r, kc_s2_r, kd_s1_r, kd_s2_r;
  logic          kc_filt_r, kc_filt_d_r, fe_r;
  logic [FW-1:0] filt_cnt_r;
  state_t        state_r;
  logic [2:0]    bitcnt_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [TW-1:0] tmo_r;
  logic          frame_err_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic good_s, push_s, pop_s, full_s, wr_s;

  assign good_s = kd_s2_r & parity_ok(shift_r, par_r);
  assign push_s = (state_r == ST_STOP) & fe_r & good_s;
  assign pop_s  = rd_en & (count_r != {CW{1'b0}});
  assign full_s = (count_r == CW'(FIFO_DEPTH));
  assign wr_s   = push_s & (~full_s | pop_s);

  assign data      = mem_r[head_r];
  assign valid     = (count_r != {CW{1'b0}});
  assign count     = count_r;
  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;

  // Pin synchronizers, clock glitch filter and registered falling-edge detect.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      kc_s1_r     <= 1'b1;
      kc_s2_r     <= 1'b1;
      kd_s1_r     <= 1'b1;
      kd_s2_r     <= 1'b1;
      kc_filt_r   <= 1'b1;
      kc_filt_d_r <= 1'b1;
      fe_r        <= 1'b0;
      filt_cnt_r  <= {FW{1'b0}};
    end else begin
      kc_s1_r     <= coe_kc;
      kc_s2_r     <= kc_s1_r;
      kd_s1_r     <= coe_kd;
      kd_s2_r     <= kd_s1_r;
      kc_filt_d_r <= kc_filt_r;
      fe_r        <= kc_filt_d_r & ~kc_filt_r;
      if (kc_s2_r == kc_filt_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        kc_filt_r  <= kc_s2_r;
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + 1'b1;
      end
    end
  end

  // Frame FSM with inter-edge timeout; a timeout discards the partial byte.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_r     <= ST_IDLE;
      bitcnt_r    <= 3'd0;
      shift_r     <= 8'd0;
      par_r       <= 1'b0;
      tmo_r       <= {TW{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (state_r == ST_IDLE) begin
        tmo_r <= {TW{1'b0}};
        if (fe_r && !kd_s2_r) begin
          state_r  <= ST_DATA;
          bitcnt_r <= 3'd0;
        end
      end else if (fe_r) begin
        tmo_r <= {TW{1'b0}};
        case (state_r)
          ST_DATA: begin
            shift_r  <= {kd_s2_r, shift_r[7:1]};
            bitcnt_r <= bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_r   <= kd_s2_r;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            frame_err_r <= ~good_s;
            state_r     <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (tmo_r == TW'(TIMEOUT - 1)) begin
        tmo_r       <= {TW{1'b0}};
        frame_err_r <= 1'b1;
        state_r     <= ST_IDLE;
      end else begin
        tmo_r <= tmo_r + 1'b1;
      end
    end
  end

  // Scancode FIFO; a push into a full FIFO succeeds only if a pop frees a slot.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[tail_r] <= shift_r;
        tail_r        <= tail_r + 1'b1;
      end
      if (pop_s) begin
        head_r <= head_r + 1'b1;
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomized scoreboard bench for ps2_frame_rx: frames are modelled at byte
// level, a monitor pops the expected queue whenever it reads the DUT head.
module tb_ps2_frame_rx;
  localparam int FL = 4;
  localparam int TO = 400;
  localparam int FD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kc = 1'b1;
  logic       kd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(FD)) dut (
    .csi_clk(clk), .csi_reset_n(rst_n), .coe_kc(kc), .coe_kd(kd),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .data(data), .valid(valid),
    .count(count), .frame_err(frame_err), .overflow(overflow)
  );

  int         checks = 0;
  int         errors = 0;
  int         err_exp = 0;
  int         err_seen = 0;
  bit         ovf_exp = 1'b0;
  bit         drain = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is good when stop=1 and data+parity has odd weight.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) err_exp++;
    else if (exp_q.size() < FD) exp_q.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    int hp;
    hp = glitch ? 20 : int'($urandom_range(15, 25));
    kd = b;
    if (glitch) begin
      wait_cyc(8); kc = 1'b0; wait_cyc(FL - 1); kc = 1'b1; wait_cyc(9);
      kc = 1'b0;
      wait_cyc(8); kc = 1'b1; wait_cyc(FL - 1); kc = 1'b0; wait_cyc(9);
    end else begin
      wait_cyc(hp); kc = 1'b0; wait_cyc(hp);
    end
    kc = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 4));
    send_bit((~^b) ^ bad_par, 1'b0);
    model_frame(b, bad_par, bad_stop);
    send_bit(~bad_stop, 1'b0);
    kd = 1'b1;
    wait_cyc(30);
  endtask

  task automatic checkpoint(input string tag);
    wait_cyc(200);
    @(negedge clk);
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_valid"}, valid, exp_q.size() != 0);
    check({tag, "_overflow"}, overflow, ovf_exp);
    check({tag, "_frame_err"}, err_seen, err_exp);
  endtask

  // Monitor: counts frame_err pulses and checks every head it pops.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) err_seen++;
      if (drain && $urandom_range(0, 3) == 0) begin
        if (valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_data: got 0x%0h expected none", data);
          end else begin
            check("pop_data", data, exp_q.pop_front());
          end
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  initial begin
    wait_cyc(5);
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_data", data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    drain = 1'b1;
    wait_cyc(10);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    checkpoint("good_1c");
    send_frame(8'hA7, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3E, 1'b0, 1'b1, 1'b0);
    checkpoint("bad_frames");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    checkpoint("glitch_f0");

    kd = 1'b1;
    wait_cyc(20); kc = 1'b0; wait_cyc(20); kc = 1'b1;
    wait_cyc(30);
    checkpoint("false_start");

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    err_exp++;
    wait_cyc(TO + 50);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    checkpoint("timeout");

    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) == 0);
      if (n % 5 == 4) checkpoint("random");
    end

    drain = 1'b0;
    wait_cyc(10);
    for (int v = 1; v <= FD + 1; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b0);
    checkpoint("fifo_full");
    drain = 1'b1;
    checkpoint("drained");
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    ovf_exp = 1'b0;
    checkpoint("clr_ovf");

    drain = 1'b0;
    wait_cyc(10);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    checkpoint("pre_reset");
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    kc = 1'b0;
    wait_cyc(5);
    @(negedge clk); rst_n = 1'b0;
    kc = 1'b1; kd = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("midrst_valid", valid, 1'b0);
    check("midrst_count", count, 4'd0);
    check("midrst_data", data, 8'h00);
    check("midrst_overflow", overflow, 1'b0);
    exp_q.delete();
    rst_n = 1'b1;
    drain = 1'b1;
    wait_cyc(10);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    checkpoint("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
